// File: rtl/ds_pkg.sv
// Shared DS-DE link definitions: control codes, the NULL alignment pattern and
// the character FSM encoding used by both link halves.
package ds_pkg;

  localparam logic [1:0] CTRL_FCT  = 2'b00;
  localparam logic [1:0] CTRL_EOP1 = 2'b01;
  localparam logic [1:0] CTRL_EOP2 = 2'b10;
  localparam logic [1:0] CTRL_ESC  = 2'b11;

  // Last seven line bits of a NULL in arrival order (oldest in MSB):
  // ESC flag + ctrl 1,1, then FCT parity 0, flag 1, ctrl 0,0.
  localparam logic [6:0] NULL_PATTERN = 7'b1110100;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_PAR,
    ST_FLAG,
    ST_DATA,
    ST_CTRL
  } ds_state_e;

  // Odd parity over previous payload, current P and current F.
  function automatic logic par_ok(input logic prev_payload, input logic p, input logic f);
    return prev_payload ^ p ^ f;
  endfunction

endpackage

// File: rtl/ds_bit_recover.sv
// DS-DE bit recovery: synchronises d/s, strobes a bit on each single-line
// transition, flags double transitions and times out a silent line.
module ds_bit_recover #(
  parameter int DISC_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  input  logic s_in,
  input  logic armed,
  output logic bit_stb,
  output logic bit_val,
  output logic both_chg,
  output logic disc_hit
);

  localparam int CW = $clog2(DISC_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] d_sync, s_sync;
  logic                   d_prev, s_prev;
  logic [CW-1:0]          disc_cnt;
  logic                   d_chg, s_chg, any_chg;

  assign d_chg    = d_sync[SYNC_STAGES-1] ^ d_prev;
  assign s_chg    = s_sync[SYNC_STAGES-1] ^ s_prev;
  assign any_chg  = d_chg | s_chg;
  assign bit_stb  = d_chg ^ s_chg;
  assign both_chg = d_chg & s_chg;
  assign bit_val  = d_sync[SYNC_STAGES-1];
  // Fires once on the cycle the count would reach the timeout; saturation stops repeats.
  assign disc_hit = armed && !any_chg && (disc_cnt == CW'(DISC_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sync   <= '0;
      s_sync   <= '0;
      d_prev   <= 1'b0;
      s_prev   <= 1'b0;
      disc_cnt <= '0;
    end else begin
      d_sync <= {d_sync[SYNC_STAGES-2:0], d_in};
      s_sync <= {s_sync[SYNC_STAGES-2:0], s_in};
      d_prev <= d_sync[SYNC_STAGES-1];
      s_prev <= s_sync[SYNC_STAGES-1];
      if (!armed || any_chg)
        disc_cnt <= '0;
      else if (disc_cnt != CW'(DISC_TIMEOUT))
        disc_cnt <= disc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ds_link_rx.sv
// DS-DE link receiver: NULL hunt, character framing, parity/escape checking
// and one-cycle event strobes.
module ds_link_rx
  import ds_pkg::*;
#(
  parameter int DISC_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       s_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_time,
  output logic       rx_eop,
  output logic       rx_eep,
  output logic       rx_fct,
  output logic       rx_null,
  output logic       link_up,
  output logic       par_err,
  output logic       esc_err,
  output logic       disc_err
);

  logic bit_stb, bit_val, both_chg, disc_hit;

  ds_bit_recover #(
    .DISC_TIMEOUT(DISC_TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rec (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (d_in),
    .s_in    (s_in),
    .armed   (link_up),
    .bit_stb (bit_stb),
    .bit_val (bit_val),
    .both_chg(both_chg),
    .disc_hit(disc_hit)
  );

  ds_state_e  state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [7:0] sh, sh_d, data_d;
  logic [6:0] hunt_sr, hunt_sr_d, hunt_nx;
  logic [1:0] code;
  logic       p_bit, p_bit_d, par_acc, par_acc_d, esc_pend, esc_pend_d, link_d, go_hunt;
  logic       valid_d, time_d, eop_d, eep_d, fct_d, null_d, perr_d, eerr_d, derr_d;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sh_d       = sh;
    hunt_sr_d  = hunt_sr;
    p_bit_d    = p_bit;
    par_acc_d  = par_acc;
    esc_pend_d = esc_pend;
    link_d     = link_up;
    data_d     = rx_data;
    valid_d    = 1'b0;
    time_d     = 1'b0;
    eop_d      = 1'b0;
    eep_d      = 1'b0;
    fct_d      = 1'b0;
    null_d     = 1'b0;
    perr_d     = 1'b0;
    eerr_d     = 1'b0;
    derr_d     = 1'b0;
    go_hunt    = 1'b0;
    hunt_nx    = {hunt_sr[5:0], bit_val};
    code       = {bit_val, sh[7]};

    if (disc_hit) begin
      derr_d  = 1'b1;
      go_hunt = 1'b1;
    end else if (both_chg && state != ST_HUNT) begin
      perr_d  = 1'b1;
      go_hunt = 1'b1;
    end else if (bit_stb) begin
      case (state)
        ST_HUNT: begin
          hunt_sr_d = hunt_nx;
          if (hunt_nx == NULL_PATTERN) begin
            // FCT payload is 00, so the next parity check starts from 0.
            null_d     = 1'b1;
            link_d     = 1'b1;
            hunt_sr_d  = '0;
            par_acc_d  = 1'b0;
            esc_pend_d = 1'b0;
            state_d    = ST_PAR;
          end
        end
        ST_PAR: begin
          p_bit_d = bit_val;
          state_d = ST_FLAG;
        end
        ST_FLAG: begin
          if (!par_ok(par_acc, p_bit, bit_val)) begin
            perr_d  = 1'b1;
            go_hunt = 1'b1;
          end else begin
            par_acc_d = 1'b0;
            cnt_d     = '0;
            state_d   = bit_val ? ST_CTRL : ST_DATA;
          end
        end
        ST_DATA: begin
          sh_d      = {bit_val, sh[7:1]};
          par_acc_d = par_acc ^ bit_val;
          cnt_d     = cnt + 1'b1;
          if (cnt == 3'd7) begin
            data_d     = sh_d;
            time_d     = esc_pend;
            valid_d    = !esc_pend;
            esc_pend_d = 1'b0;
            state_d    = ST_PAR;
          end
        end
        ST_CTRL: begin
          sh_d      = {bit_val, sh[7:1]};
          par_acc_d = par_acc ^ bit_val;
          cnt_d     = cnt + 1'b1;
          if (cnt == 3'd1) begin
            state_d = ST_PAR;
            case (code)
              CTRL_FCT: begin
                null_d     = esc_pend;
                fct_d      = !esc_pend;
                esc_pend_d = 1'b0;
              end
              CTRL_EOP1: begin
                eop_d   = !esc_pend;
                eerr_d  = esc_pend;
                go_hunt = esc_pend;
              end
              CTRL_EOP2: begin
                eep_d   = !esc_pend;
                eerr_d  = esc_pend;
                go_hunt = esc_pend;
              end
              default: begin
                eerr_d     = esc_pend;
                go_hunt    = esc_pend;
                esc_pend_d = 1'b1;
              end
            endcase
          end
        end
        default: go_hunt = 1'b1;
      endcase
    end

    if (go_hunt) begin
      state_d   = ST_HUNT;
      link_d    = 1'b0;
      hunt_sr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      cnt      <= '0;
      sh       <= '0;
      hunt_sr  <= '0;
      p_bit    <= 1'b0;
      par_acc  <= 1'b0;
      esc_pend <= 1'b0;
      link_up  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_time  <= 1'b0;
      rx_eop   <= 1'b0;
      rx_eep   <= 1'b0;
      rx_fct   <= 1'b0;
      rx_null  <= 1'b0;
      par_err  <= 1'b0;
      esc_err  <= 1'b0;
      disc_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sh       <= sh_d;
      hunt_sr  <= hunt_sr_d;
      p_bit    <= p_bit_d;
      par_acc  <= par_acc_d;
      esc_pend <= esc_pend_d;
      link_up  <= link_d;
      rx_data  <= data_d;
      rx_valid <= valid_d;
      rx_time  <= time_d;
      rx_eop   <= eop_d;
      rx_eep   <= eep_d;
      rx_fct   <= fct_d;
      rx_null  <= null_d;
      par_err  <= perr_d;
      esc_err  <= eerr_d;
      disc_err <= derr_d;
    end
  end

endmodule

// File: tb/tb_ds_link_rx.sv
// Self-checking bench for ds_link_rx: a character-level DS transmitter model
// feeds the receiver; expected events queue up and a monitor pops on each strobe.
module tb_ds_link_rx;

  localparam int DISC_TIMEOUT = 64;
  localparam int SYNC_STAGES  = 2;

  logic       clk = 1'b0, rst_n = 1'b0, d_line = 1'b0, s_line = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_time, rx_eop, rx_eep, rx_fct, rx_null;
  logic       link_up, par_err, esc_err, disc_err;

  ds_link_rx #(.DISC_TIMEOUT(DISC_TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_line), .s_in(s_line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_time(rx_time), .rx_eop(rx_eop),
    .rx_eep(rx_eep), .rx_fct(rx_fct), .rx_null(rx_null), .link_up(link_up),
    .par_err(par_err), .esc_err(esc_err), .disc_err(disc_err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_VALID, EV_TIME, EV_EOP, EV_EEP, EV_FCT, EV_NULL, EV_PAR, EV_ESC, EV_DISC} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, last_drive_cyc = 0, last_valid_cyc = 0;
  logic prev_par = 1'b0;
  bit   link_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input ev_e k, input logic [7:0] dat);
    ev_t e;
    e.kind = k;
    e.data = dat;
    exp_q.push_back(e);
  endtask

  // DS encoding: d carries the bit, s toggles whenever d does not.
  task automatic tx_bit(input logic b, input int hold);
    @(posedge clk);
    #1;
    if (b == d_line) s_line = ~s_line;
    d_line = b;
    last_drive_cyc = cyc;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic tx_char(input bit is_ctrl, input logic [7:0] val, input bit bad_par, input int last_hold);
    logic p, pay;
    int   n;
    p = 1'b1 ^ prev_par ^ is_ctrl;
    if (bad_par) p = ~p;
    tx_bit(p, $urandom_range(3, 6));
    tx_bit(is_ctrl, $urandom_range(3, 6));
    n   = is_ctrl ? 2 : 8;
    pay = 1'b0;
    for (int i = 0; i < n; i++) begin
      tx_bit(val[i], (i == n - 1 && last_hold > 0) ? last_hold : $urandom_range(3, 6));
      pay ^= val[i];
    end
    prev_par = pay;
  endtask

  task automatic send_null();
    push(EV_NULL, 8'h00);
    link_m = 1'b1;
    tx_char(1, 8'h03, 0, 0);
    tx_char(1, 8'h00, 0, 0);
  endtask

  task automatic send_data(input logic [7:0] v);
    push(EV_VALID, v);
    tx_char(0, v, 0, 0);
  endtask

  task automatic send_time(input logic [7:0] v);
    push(EV_TIME, v);
    tx_char(1, 8'h03, 0, 0);
    tx_char(0, v, 0, 0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(exp_q.size() == 0, {name, " drain"}, exp_q.size(), 0);
    @(negedge clk);
    check(link_up == link_m, {name, " link_up"}, int'(link_up), int'(link_m));
  endtask

  // Monitor: every strobe must be single, expected, and in order.
  always @(negedge clk) begin : mon
    logic [8:0] st;
    ev_e        k;
    ev_t        e;
    if (rst_n) begin
      st = {rx_valid, rx_time, rx_eop, rx_eep, rx_fct, rx_null, par_err, esc_err, disc_err};
      if (st != 9'd0) begin
        if      (rx_valid) k = EV_VALID;
        else if (rx_time)  k = EV_TIME;
        else if (rx_eop)   k = EV_EOP;
        else if (rx_eep)   k = EV_EEP;
        else if (rx_fct)   k = EV_FCT;
        else if (rx_null)  k = EV_NULL;
        else if (par_err)  k = EV_PAR;
        else if (esc_err)  k = EV_ESC;
        else               k = EV_DISC;
        if (rx_valid) last_valid_cyc = cyc;
        check($countones(st) == 1, "strobe exclusive", int'(st), 0);
        if (exp_q.size() == 0) begin
          check(0, $sformatf("unexpected event %s", k.name()), int'(k), -1);
        end else begin
          e = exp_q.pop_front();
          check(e.kind == k, "event kind", int'(k), int'(e.kind));
          if (e.kind == k && (k == EV_VALID || k == EV_TIME))
            check(rx_data == e.data, $sformatf("rx_data on %s", k.name()), int'(rx_data), int'(e.data));
        end
      end
    end
  end

  initial begin : stim
    int t;
    // Reset held with idle lines
    repeat (100) begin
      @(negedge clk);
      check({rx_data, rx_valid, rx_time, rx_eop, rx_eep, rx_fct, rx_null, link_up,
             par_err, esc_err, disc_err} == 18'd0, "reset outputs",
            int'({rx_data, rx_valid, rx_time, rx_eop, rx_eep, rx_fct, rx_null, link_up,
                  par_err, esc_err, disc_err}), 0);
    end
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check(link_up == 1'b0, "idle link_up", int'(link_up), 0);

    // Three NULLs then 0xA5, with emit latency measured on the last bit
    repeat (3) send_null();
    push(EV_VALID, 8'hA5);
    tx_char(0, 8'hA5, 0, 8);
    check(last_valid_cyc - last_drive_cyc == SYNC_STAGES + 1, "emit latency",
          last_valid_cyc - last_drive_cyc, SYNC_STAGES + 1);
    drain("nulls+A5");

    // Data, EOP_1, EOP_2
    send_null();
    send_data(8'h3C);
    push(EV_EOP, 8'h00); tx_char(1, 8'h01, 0, 0);
    push(EV_EEP, 8'h00); tx_char(1, 8'h02, 0, 0);
    push(EV_FCT, 8'h00); tx_char(1, 8'h00, 0, 0);
    drain("eop/eep");

    // Bad parity drops the link; a NULL restores it
    send_null();
    push(EV_PAR, 8'h00);
    link_m = 1'b0;
    tx_char(0, 8'h00, 1, 0);
    drain("parity err");
    send_null();
    drain("parity recover");

    // Frozen lines: exactly one disconnect
    send_null();
    push(EV_DISC, 8'h00);
    link_m = 1'b0;
    repeat (DISC_TIMEOUT + 30) @(posedge clk);
    drain("disconnect");
    repeat (DISC_TIMEOUT + 10) @(posedge clk);
    check(link_up == 1'b0, "disc link stays down", int'(link_up), 0);

    // Escape errors and time-code
    send_null();
    push(EV_ESC, 8'h00);
    link_m = 1'b0;
    tx_char(1, 8'h03, 0, 0);
    tx_char(1, 8'h03, 0, 0);
    drain("esc+esc");
    send_null();
    push(EV_ESC, 8'h00);
    link_m = 1'b0;
    tx_char(1, 8'h03, 0, 0);
    tx_char(1, 8'h01, 0, 0);
    drain("esc+eop");
    send_null();
    send_time(8'h15);
    drain("timecode");

    // Randomized legal traffic
    for (int i = 0; i < 200; i++) begin
      t = $urandom_range(0, 9);
      case (t)
        0, 1, 2, 3: send_data(8'($urandom));
        4:          send_time(8'($urandom));
        5:          begin push(EV_FCT, 8'h00); tx_char(1, 8'h00, 0, 0); end
        6:          begin push(EV_EOP, 8'h00); tx_char(1, 8'h01, 0, 0); end
        7:          begin push(EV_EEP, 8'h00); tx_char(1, 8'h02, 0, 0); end
        default:    send_null();
      endcase
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
